// File: rtl/gfx_pkg.sv
// gfx_pkg: shared types and helpers for the shape schedulers.
//   arb_state_t  - scheduler states (IDLE, LOAD, RUN)
//   line_state_t - line engine states
//   rr_next      - one-hot round-robin pick from a request vector of up to
//                  RR_MAX clients, starting the search just after 'last'
package gfx_pkg;

  localparam int RR_MAX = 16;
  localparam int RR_IDW = 4;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} arb_state_t;

  typedef enum logic [1:0] {LN_IDLE, LN_INIT0, LN_INIT1, LN_DRAW} line_state_t;

  // n is the number of live clients (2..RR_MAX). The search index wraps
  // explicitly so that non-power-of-2 client counts rotate correctly; the
  // previous winner is visited last (i == n).
  function automatic logic [RR_MAX-1:0] rr_next(
    input logic [RR_MAX-1:0] req,
    input logic [RR_IDW-1:0] last,
    input int                n
  );
    logic [RR_MAX-1:0] pick;
    int                idx;
    pick = '0;
    for (int i = 1; i <= RR_MAX; i++) begin
      idx = int'(last) + i;
      if (idx >= n) idx = idx - n;
      if (i <= n && pick == '0 && req[idx[RR_IDW-1:0]]) pick[idx[RR_IDW-1:0]] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/draw_line.sv
// draw_line: Bresenham line engine with signed coordinates.
//   clk, rst      - clock, synchronous active-high reset
//   start         - begin a line from (x0,y0) to (x1,y1); endpoints must stay
//                   stable until done
//   oe            - advance enable; drawing stalls while low
//   x, y          - current pixel position
//   drawing       - (x,y) is a valid pixel this cycle
//   done          - one-cycle pulse the cycle after the final pixel
// Lines are always walked with y increasing; endpoints are swapped when
// y0 > y1. Two setup cycles (INIT0, INIT1) follow start.
module draw_line
  import gfx_pkg::*;
#(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    drawing,
  output logic                    done
);

  // Error term width: deltas need CORDW+1 bits and twice the error one more;
  // one spare bit keeps the comparisons clear of overflow.
  localparam int EW = CORDW + 3;

  function automatic logic signed [EW-1:0] sx(input logic signed [CORDW-1:0] v);
    return {{(EW-CORDW){v[CORDW-1]}}, v};
  endfunction

  line_state_t state, state_n;

  logic                    swap, right, movx, movy, at_end;
  logic signed [CORDW-1:0] xa, ya, xb, yb, x_end, y_end;
  logic signed [EW-1:0]    dx, dy, err, err2;

  always_comb begin
    swap = (y0 > y1);
    xa   = swap ? x1 : x0;
    ya   = swap ? y1 : y0;
    xb   = swap ? x0 : x1;
    yb   = swap ? y0 : y1;
  end

  always_comb begin
    err2   = err <<< 1;
    movx   = (err2 >= dy);
    movy   = (err2 <= dx);
    at_end = (x == x_end) && (y == y_end);
  end

  always_comb begin
    state_n = state;
    case (state)
      LN_IDLE:  if (start) state_n = LN_INIT0;
      LN_INIT0: state_n = LN_INIT1;
      LN_INIT1: state_n = LN_DRAW;
      LN_DRAW:  if (oe && at_end) state_n = LN_IDLE;
      default:  state_n = LN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LN_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state == LN_DRAW) && oe && at_end;
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      LN_IDLE: if (start) right <= (xa < xb);
      LN_INIT0: begin
        dx <= right ? (sx(xb) - sx(xa)) : (sx(xa) - sx(xb));
        dy <= sx(ya) - sx(yb);
      end
      LN_INIT1: begin
        err   <= dx + dy;
        x     <= xa;
        y     <= ya;
        x_end <= xb;
        y_end <= yb;
      end
      LN_DRAW: if (oe && !at_end) begin
        if (movx) x <= right ? (x + CORDW'(1)) : (x - CORDW'(1));
        if (movy) y <= y + CORDW'(1);
        err <= err + (movx ? dy : '0) + (movy ? dx : '0);
      end
      default: ;
    endcase
  end

  assign drawing = (state == LN_DRAW) && oe;

endmodule

// File: rtl/line_arbiter.sv
// line_arbiter: round-robin scheduler sharing one draw_line engine among
// NREQ clients.
//   clk, rst        - clock, asynchronous active-high reset
//   req[i]          - client i wants a line; held until ack[i]
//   x0_in..y1_in    - packed endpoints, client i at [i*CORDW +: CORDW]
//   oe              - framebuffer output enable; stalls drawing when low
//   ack[i]          - one-cycle pulse: client i's endpoints were latched
//   done[i]         - one-cycle pulse: client i's line is finished
//   grant, owner    - one-hot / binary owner of the engine (zero when idle)
//   x, y, drawing   - pixel stream from the engine, valid only in RUN
//   busy            - scheduler not idle
module line_arbiter
  import gfx_pkg::*;
#(
  parameter  int CORDW = 16,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*CORDW-1:0]     x0_in,
  input  logic [NREQ*CORDW-1:0]     y0_in,
  input  logic [NREQ*CORDW-1:0]     x1_in,
  input  logic [NREQ*CORDW-1:0]     y1_in,
  input  logic                      oe,
  output logic [NREQ-1:0]           ack,
  output logic [NREQ-1:0]           done,
  output logic [NREQ-1:0]           grant,
  output logic [IDW-1:0]            owner,
  output logic signed [CORDW-1:0]   x,
  output logic signed [CORDW-1:0]   y,
  output logic                      drawing,
  output logic                      busy
);

  arb_state_t state, state_n;

  logic [NREQ-1:0]         win, ack_n;
  logic [IDW-1:0]          win_idx, last;
  logic signed [CORDW-1:0] lx0, ly0, lx1, ly1;
  logic signed [CORDW-1:0] eng_x, eng_y;
  logic                    eng_drawing, eng_done, start;

  always_comb begin
    win = NREQ'(rr_next(RR_MAX'(req), RR_IDW'(last), NREQ));
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = IDW'(i);
    end
  end

  always_comb begin
    state_n = state;
    ack_n   = '0;
    case (state)
      IDLE: if (req != '0) begin
        state_n = LOAD;
        ack_n   = win;
      end
      LOAD:    state_n = RUN;
      RUN:     if (eng_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ack   <= '0;
      grant <= '0;
      owner <= '0;
      last  <= IDW'(NREQ - 1);
    end else begin
      state <= state_n;
      ack   <= ack_n;
      if (state == IDLE && req != '0) begin
        grant <= win;
        owner <= win_idx;
      end else if (state == RUN && eng_done) begin
        grant <= '0;
        owner <= '0;
        last  <= owner;
      end
    end
  end

  // Endpoint latch: held from LOAD until the line completes, so clients are
  // free to change their inputs once acknowledged.
  always_ff @(posedge clk) begin
    if (state == IDLE && req != '0) begin
      lx0 <= x0_in[int'(win_idx)*CORDW +: CORDW];
      ly0 <= y0_in[int'(win_idx)*CORDW +: CORDW];
      lx1 <= x1_in[int'(win_idx)*CORDW +: CORDW];
      ly1 <= y1_in[int'(win_idx)*CORDW +: CORDW];
    end
  end

  assign start = (state == LOAD);

  draw_line #(.CORDW(CORDW)) u_line (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .oe      (oe),
    .x0      (lx0),
    .y0      (ly0),
    .x1      (lx1),
    .y1      (ly1),
    .x       (eng_x),
    .y       (eng_y),
    .drawing (eng_drawing),
    .done    (eng_done)
  );

  // Engine outputs are gated by RUN so an asynchronous reset silences the
  // pixel stream immediately, before the engine's own synchronous reset.
  assign done    = (state == RUN && eng_done) ? grant : '0;
  assign x       = (state == RUN) ? eng_x : '0;
  assign y       = (state == RUN) ? eng_y : '0;
  assign drawing = (state == RUN) && eng_drawing;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_line_arbiter.sv
module tb_line_arbiter;

  localparam int CORDW = 16;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, oe;
  logic [NREQ-1:0]         req, ack, done, grant;
  logic [NREQ*CORDW-1:0]   x0_in, y0_in, x1_in, y1_in;
  logic [IDW-1:0]          owner;
  logic signed [CORDW-1:0] x, y;
  logic                    drawing, busy;

  logic [2:0]              req3, ack3, done3, grant3;
  logic [3*CORDW-1:0]      x0_in3, y0_in3, x1_in3, y1_in3;
  logic [1:0]              owner3;
  logic signed [CORDW-1:0] x3, y3;
  logic                    drawing3, busy3;

  line_arbiter #(.CORDW(CORDW), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req),
    .x0_in(x0_in), .y0_in(y0_in), .x1_in(x1_in), .y1_in(y1_in),
    .oe(oe), .ack(ack), .done(done), .grant(grant), .owner(owner),
    .x(x), .y(y), .drawing(drawing), .busy(busy)
  );

  line_arbiter #(.CORDW(CORDW), .NREQ(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3),
    .x0_in(x0_in3), .y0_in(y0_in3), .x1_in(x1_in3), .y1_in(y1_in3),
    .oe(oe), .ack(ack3), .done(done3), .grant(grant3), .owner(owner3),
    .x(x3), .y(y3), .drawing(drawing3), .busy(busy3)
  );

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] req;
    int ax, ay, bx, by;
    int win, npix, fx, fy, lx, ly;
  } vec_t;

  vec_t vec [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] oh(input int i);
    return 32'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int c, input int ax, input int ay, input int bx, input int by);
    x0_in[c*CORDW +: CORDW] = CORDW'(ax);
    y0_in[c*CORDW +: CORDW] = CORDW'(ay);
    x1_in[c*CORDW +: CORDW] = CORDW'(bx);
    y1_in[c*CORDW +: CORDW] = CORDW'(by);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    req3 = '0;
    oe   = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n, npix, fx, fy, lx, ly, acks, ph, bad, seen0, px3, py3;
    int ex [4];
    int ey [4];

    vec[0] = '{4'b1111,  0,  0,  0,  0, 0, 1,  0,  0,  0,  0};
    vec[1] = '{4'b1111,  1,  1,  4,  3, 1, 4,  1,  1,  4,  3};
    vec[2] = '{4'b0101, -2,  3, -5,  3, 2, 4, -2,  3, -5,  3};
    vec[3] = '{4'b1001,  7,  9,  7,  5, 3, 5,  7,  5,  7,  9};
    vec[4] = '{4'b0011,  0,  0,  2,  2, 0, 3,  0,  0,  2,  2};
    vec[5] = '{4'b0011,  3,  0,  0,  1, 1, 4,  3,  0,  0,  1};
    vec[6] = '{4'b0100, -1, -1, -1, -1, 2, 1, -1, -1, -1, -1};
    vec[7] = '{4'b1000,  0,  0,  1,  0, 3, 2,  0,  0,  1,  0};

    x0_in = '0; y0_in = '0; x1_in = '0; y1_in = '0;
    x0_in3 = '0; y0_in3 = '0; x1_in3 = '0; y1_in3 = '0;
    req = '0; req3 = '0; oe = 1'b1;

    // Reset state
    rst = 1'b1;
    #1;
    tick();
    tick();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drawing", 32'(drawing), 0);
    chk("rst_xy", 32'({x, y}), 0);
    rst = 1'b0;

    // Horizontal line (0,0)->(3,0) from client 0 with exact cycle timing
    set_line(0, 0, 0, 3, 0);
    req = 4'b0001;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      if (cyc == 1) begin
        chk("a_ack", 32'(ack), oh(0));
        chk("a_grant", 32'(grant), oh(0));
        chk("a_busy", 32'(busy), 1);
        req = '0;
      end else if (cyc < 4) begin
        chk("a_init_nodraw", 32'(drawing), 0);
      end else if (cyc < 8) begin
        chk("a_drawing", 32'(drawing), 1);
        chk("a_x", 32'(x), 32'(cyc - 4));
        chk("a_y", 32'(y), 0);
      end else if (cyc == 8) begin
        chk("a_done", 32'(done), oh(0));
        chk("a_done_nodraw", 32'(drawing), 0);
      end else begin
        chk("a_grant_clear", 32'(grant), 0);
        chk("a_idle", 32'(busy), 0);
      end
    end

    // All four clients requesting continuously with one-pixel lines
    do_reset();
    for (int c = 0; c < 4; c++) set_line(c, 10 + c, 20 + c, 10 + c, 20 + c);
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      int c;
      c = k % 4;
      chk("rr_ack", 32'(ack), oh(c));
      chk("rr_grant", 32'(grant), oh(c));
      chk("rr_owner", 32'(owner), 32'(c));
      acks = 0;
      repeat (3) begin
        tick();
        if (ack != '0) acks++;
      end
      chk("rr_drawing", 32'(drawing), 1);
      chk("rr_px", 32'({x, y}), 32'({CORDW'(10 + c), CORDW'(20 + c)}));
      tick();
      if (ack != '0) acks++;
      chk("rr_done", 32'(done), oh(c));
      tick();
      if (ack != '0) acks++;
      chk("rr_idle", 32'(busy), 0);
      chk("rr_single_ack", 32'(acks), 0);
      if (k == 4) req = '0;
      tick();
    end
    chk("rr_stop", 32'(ack), 0);
    while (busy) tick();

    // Table of lines with varying request patterns
    do_reset();
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < 4; c++) set_line(c, vec[v].ax, vec[v].ay, vec[v].bx, vec[v].by);
      req = vec[v].req;
      n = 0;
      do begin tick(); n++; end while (ack == '0 && n < 10);
      chk("t_ack", 32'(ack), oh(vec[v].win));
      chk("t_grant", 32'(grant), oh(vec[v].win));
      chk("t_owner", 32'(owner), 32'(vec[v].win));
      req = '0;
      npix = 0; n = 0; fx = 0; fy = 0; lx = 0; ly = 0;
      while (done == '0 && n < 60) begin
        tick();
        n++;
        if (drawing) begin
          if (npix == 0) begin fx = int'(x); fy = int'(y); end
          lx = int'(x); ly = int'(y);
          npix++;
        end
      end
      chk("t_done", 32'(done), oh(vec[v].win));
      chk("t_npix", 32'(npix), 32'(vec[v].npix));
      chk("t_first", 32'({CORDW'(fx), CORDW'(fy)}), 32'({CORDW'(vec[v].fx), CORDW'(vec[v].fy)}));
      chk("t_last", 32'({CORDW'(lx), CORDW'(ly)}), 32'({CORDW'(vec[v].lx), CORDW'(vec[v].ly)}));
      tick();
      chk("t_grant_clear", 32'(grant), 0);
    end

    // Client 2 line (5,5)->(2,8) with oe toggling every cycle
    ex = '{5, 4, 3, 2};
    ey = '{5, 6, 7, 8};
    set_line(2, 5, 5, 2, 8);
    req = 4'b0100;
    tick();
    chk("oe_ack", 32'(ack), oh(2));
    req = '0;
    npix = 0; bad = 0; ph = 0; n = 0; lx = 0; ly = 0;
    while (done == '0 && n < 60) begin
      tick();
      oe = (ph % 2 == 0);
      ph++;
      n++;
      #1;
      if (grant != 4'b0100 || !busy) bad++;
      if (drawing) begin
        if (npix < 4) begin
          chk("oe_px", 32'({x, y}), 32'({CORDW'(ex[npix]), CORDW'(ey[npix])}));
        end
        lx = int'(x); ly = int'(y);
        npix++;
      end
    end
    chk("oe_done", 32'(done), oh(2));
    chk("oe_npix", 32'(npix), 4);
    chk("oe_last_before_done", 32'({CORDW'(lx), CORDW'(ly)}), 32'({CORDW'(2), CORDW'(8)}));
    chk("oe_grant_steady", 32'(bad), 0);
    oe = 1'b1;
    tick();

    // Client 1 changes its endpoints right after ack
    set_line(1, 0, 2, 2, 2);
    req = 4'b0010;
    tick();
    chk("hold_ack", 32'(ack), oh(1));
    req = '0;
    tick();
    set_line(1, 9, 9, 9, 9);
    npix = 0; n = 0; fx = 0; lx = 0; ly = 0;
    while (done == '0 && n < 40) begin
      tick();
      n++;
      if (drawing) begin
        if (npix == 0) fx = int'(x);
        lx = int'(x); ly = int'(y);
        npix++;
      end
    end
    chk("hold_done", 32'(done), oh(1));
    chk("hold_npix", 32'(npix), 3);
    chk("hold_first_x", 32'(fx), 0);
    chk("hold_last", 32'({CORDW'(lx), CORDW'(ly)}), 32'({CORDW'(2), CORDW'(2)}));
    tick();

    // Asynchronous reset in the middle of a line
    set_line(0, 0, 0, 9, 0);
    req = 4'b0001;
    tick();
    req = '0;
    repeat (4) tick();
    chk("ar_drawing_before", 32'(drawing), 1);
    seen0 = 0;
    rst = 1'b1;
    #1;
    chk("ar_ack", 32'(ack), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_grant", 32'(grant), 0);
    chk("ar_owner", 32'(owner), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_drawing", 32'(drawing), 0);
    chk("ar_xy", 32'({x, y}), 0);
    tick();
    rst = 1'b0;
    set_line(3, 4, 4, 4, 4);
    req = 4'b1000;
    tick();
    chk("ar_req3_ack", 32'(ack), oh(3));
    chk("ar_req3_owner", 32'(owner), 3);
    req = '0;
    n = 0; lx = 0; ly = 0;
    while (done == '0 && n < 40) begin
      tick();
      n++;
      if (done[0]) seen0++;
      if (drawing) begin lx = int'(x); ly = int'(y); end
    end
    chk("ar_req3_done", 32'(done), oh(3));
    chk("ar_req3_px", 32'({CORDW'(lx), CORDW'(ly)}), 32'({CORDW'(4), CORDW'(4)}));
    chk("ar_no_done0", 32'(seen0), 0);
    tick();

    // Three-client instance: pointer wraps 2 -> 0
    do_reset();
    for (int c = 0; c < 3; c++) begin
      x0_in3[c*CORDW +: CORDW] = CORDW'(1);
      y0_in3[c*CORDW +: CORDW] = CORDW'(1);
      x1_in3[c*CORDW +: CORDW] = CORDW'(1);
      y1_in3[c*CORDW +: CORDW] = CORDW'(1);
    end
    req3 = 3'b101;
    for (int k = 0; k < 3; k++) begin
      int e;
      e = (k == 1) ? 2 : 0;
      n = 0;
      do begin tick(); n++; end while (ack3 == '0 && n < 20);
      chk("n3_ack", 32'(ack3), oh(e));
      chk("n3_grant", 32'(grant3), oh(e));
      chk("n3_owner", 32'(owner3), 32'(e));
      if (k == 2) req3 = '0;
      n = 0; px3 = 0; py3 = 0;
      do begin
        tick();
        n++;
        if (drawing3) begin px3 = int'(x3); py3 = int'(y3); end
      end while (done3 == '0 && n < 20);
      chk("n3_done", 32'(done3), oh(e));
      chk("n3_px", 32'({CORDW'(px3), CORDW'(py3)}), 32'({CORDW'(1), CORDW'(1)}));
    end
    tick();
    tick();
    chk("n3_idle", 32'(busy3), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/line_arbiter.md
# line_arbiter

Round-robin scheduler that shares one `draw_line` engine between `NREQ` independent drawing clients (for example, a UI overlay, a sprite outliner and a debug grid). It accepts one line request at a time and latches that request's endpoints. It then sequences the engine's `start` and forwards its pixel stream, tagged with the owning requester. Completion is returned to the correct client. It sits between the client FSMs and the framebuffer write port.

## Interface
- `CORDW`, 16: signed coordinate width, passed to the engine.
- `NREQ`, 4: number of requesters, 2..16; `IDW = $clog2(NREQ)`.
- `clk` input 1: clock.
- `rst` input 1: reset. One clock; reset is asynchronous and active-high.
- `req` input NREQ: per-client request level; held until that client's `ack`.
- `x0_in`, `y0_in`, `x1_in`, `y1_in` input NREQ*CORDW each: packed endpoints; client i occupies bits [i*CORDW +: CORDW].
- `oe` input 1: output enable from the framebuffer; stalls drawing when low.
- `ack` output NREQ: one-cycle pulse; endpoints of that client were latched.
- `done` output NREQ: one-cycle pulse; that client's line is complete.
- `grant` output NREQ: one-hot owner of the engine; all-zero when idle.
- `owner` output IDW: binary index of the granted client; valid while `grant != 0`.
- `x`, `y` output CORDW signed: engine drawing position.
- `drawing` output 1: pixel valid this cycle (engine drawing and `oe`).
- `busy` output 1: arbiter not in IDLE.

## Operation
- States are IDLE, LOAD, RUN.
- **IDLE**:
  - If `req` is non-zero, pick a winner by round-robin. Search starts at `last+1` (mod NREQ); `last` is the most recent winner and resets to NREQ-1, so client 0 wins first.
  - Latch the winner's four coordinates, set `grant`/`owner`, and go to LOAD.
  - `ack[winner]` pulses in the IDLE→LOAD transition cycle, registered, so it is high in the first LOAD cycle.
- **LOAD**: drive engine `start`=1 for exactly one cycle with the latched endpoints, then go to RUN.
- **RUN**:
  - Engine `x`, `y` and `drawing` pass straight through.
  - When engine `done`=1, `done[owner]` is asserted combinationally the same cycle. `grant` clears and state goes to IDLE at the next edge.
  - `last` updates to `owner` at that same edge.
- Latched endpoints are stable from LOAD until IDLE. Client inputs may change freely after `ack`.
- A client whose `req` drops before `ack` is simply not granted; no error is raised.
- A client may re-raise `req` in the cycle after its own `done`. It is served again only after every other pending client has had a turn.
- Arithmetic:
  - The pointer increments modulo NREQ; the non-power-of-2 case wraps explicitly.
  - Coordinates are never modified; signed semantics are kept by the engine.

## Timing
- Reset values:
  - `ack`, `done`, `grant`, `owner` = 0; `busy`, `drawing` = 0; `x`, `y` = 0; `last` = NREQ-1; state IDLE.
  - The engine `rst` is driven from `rst`. The engine resets synchronously, so `rst` must be held at least 1 clock.
- Request in IDLE at cycle n gives the following sequence:
  - `ack` and `grant` high at n+1 (LOAD).
  - Engine `start` at n+1, sampled at the n+1→n+2 edge.
  - Engine INIT at n+2 and n+3.
  - First `drawing` at n+4 if `oe`=1.
- A single-pixel line (p0==p1) with `oe` high gives `drawing` at n+4, `done` at n+5, and IDLE at n+6.
- Minimum gap between successive grants is 1 IDLE cycle. Back-to-back requests are therefore accepted at done+1 and ack'd at done+2.
- `oe` low stalls the engine in RUN indefinitely. `grant` and `busy` stay high throughout.
- Asynchronous `rst` mid-RUN aborts the line: outputs clear at once, no `done` is issued, and the owner must re-request.

## Structure
- Shared package `gfx_pkg` holds the state enum `arb_state_t` (IDLE, LOAD, RUN) and a `rr_next` function (one-hot round-robin pick given `req` and `last`). Both are reused by future shape schedulers.
- The one sub-module is `draw_line` (parameter CORDW), instantiated once. Arbitration stays inline; no separate arbiter module.

## Test plan
- Reset, then `req`=0001, line (0,0)→(3,0), `oe`=1:
  - `ack[0]` at cycle 1.
  - Pixels (0,0),(1,0),(2,0),(3,0) on cycles 4–7.
  - `done[0]` at 8, `grant`=0000 at 9.
- `req`=1111 held with one-pixel lines: grants in order 0,1,2,3,0 and each `ack` occurs exactly once per grant.
- Client 2 line (5,5)→(2,8) with `oe` toggling 1,0,1,0: 4 pixels appear with no duplicates, `grant` stays 0100 throughout, and `done[2]` arrives only after (2,8).
- Client 1 changes `x0_in` the cycle after `ack`: the drawn line still uses the originally latched endpoints.
- Assert `rst` for 1 cycle mid-line: all outputs are 0 immediately, no `done` is issued, and a new `req[3]` is served from client 3 with `ack` one cycle later.
- NREQ=3: `last`=2 with `req`=101 grants client 0, then client 2; the pointer wraps correctly.
